// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the sync_fifo_adv FIFO slice.
//   fifo_type_e : selects registered-read (STANDARD) or first-word-fall-through (FWFT).
//   count_width : number of bits needed to hold an occupancy of 0..depth inclusive.
package sync_fifo_pkg;

    typedef enum logic [0:0] {
        STANDARD = 1'b0,
        FWFT     = 1'b1
    } fifo_type_e;

    // Occupancy must represent the value "depth" itself, hence depth + 1 states.
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for sync_fifo_adv (one write port, one read port).
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset (clears only the read register)
//   we    : write enable, wdata stored at waddr
//   re    : read enable (registered-read mode only)
//   raddr : read address
//   rdata : read data; combinational in FWFT mode, registered in STANDARD mode
// The array itself is never reset so it can map onto block or distributed RAM.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int         DATA_WIDTH = 8,
    parameter int         FIFO_DEPTH = 256,
    parameter int         ADDR_W     = 8,
    parameter fifo_type_e FIFO_TYPE  = STANDARD
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    generate
        if (FIFO_TYPE == FWFT) begin : g_async_rd
            // Head word must be visible without a read strobe.
            logic unused_s;
            assign unused_s = &{1'b0, re, rst};
            assign rdata    = mem_r[raddr];
        end else begin : g_reg_rd
            logic [DATA_WIDTH-1:0] rdata_r;

            // Registered read port; holds its value when no read is accepted
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_r <= {DATA_WIDTH{1'b0}};
                end else if (re) begin
                    rdata_r <= mem_r[raddr];
                end
            end

            assign rdata = rdata_r;
        end
    endgenerate

endmodule

// File: rtl/sync_fifo_adv.sv
// Synchronous FIFO with registered status flags, sticky error flags and a
// selectable read style.
//   clk, rst             : clock and synchronous active-high reset
//   wr_en, din           : write request and data (ignored while full)
//   rd_en                : read request (STANDARD) / pop (FWFT), ignored while empty
//   err_clr              : clears overflow/underflow unless a new error arrives
//   dout, valid          : read data and its qualifier
//   full, empty          : occupancy == FIFO_DEPTH / occupancy == 0
//   almost_full/_empty   : count >= AFULL_THRESH / count <= AEMPTY_THRESH
//   count                : current occupancy
//   overflow, underflow  : sticky error flags
// Depth need not be a power of two; pointers wrap explicitly at FIFO_DEPTH-1.
module sync_fifo_adv
    import sync_fifo_pkg::*;
#(
    parameter int         DATA_WIDTH    = 8,
    parameter int         FIFO_DEPTH    = 256,
    parameter fifo_type_e FIFO_TYPE     = STANDARD,
    parameter int         AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter int         AEMPTY_THRESH = 2,
    localparam int        CNT_W         = count_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int ADDR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

    generate
        if (DATA_WIDTH < 1) begin : g_bad_width
            $fatal(1, "sync_fifo_adv: DATA_WIDTH must be >= 1");
        end
        if (FIFO_DEPTH < 2) begin : g_bad_depth
            $fatal(1, "sync_fifo_adv: FIFO_DEPTH must be >= 2");
        end
        if (AFULL_THRESH < 0 || AFULL_THRESH > FIFO_DEPTH) begin : g_bad_afull
            $fatal(1, "sync_fifo_adv: AFULL_THRESH outside 0..FIFO_DEPTH");
        end
        if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > FIFO_DEPTH) begin : g_bad_aempty
            $fatal(1, "sync_fifo_adv: AEMPTY_THRESH outside 0..FIFO_DEPTH");
        end
    endgenerate

    logic [ADDR_W-1:0]     wr_ptr_r;
    logic [ADDR_W-1:0]     rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic [CNT_W-1:0]      count_nxt_s;
    logic                  full_r;
    logic                  empty_r;
    logic                  afull_r;
    logic                  aempty_r;
    logic                  ovf_r;
    logic                  udf_r;
    logic                  wr_acc_s;
    logic                  rd_acc_s;
    logic [DATA_WIDTH-1:0] ram_rdata_s;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] ptr);
        if (ptr == ADDR_W'(FIFO_DEPTH - 1)) begin
            return {ADDR_W{1'b0}};
        end else begin
            return ptr + ADDR_W'(1'b1);
        end
    endfunction

    // Acceptance is judged on the registered flags only, and the next count follows.
    always_comb begin
        wr_acc_s    = wr_en && !full_r;
        rd_acc_s    = rd_en && !empty_r;
        count_nxt_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1'b1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1'b1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy, status flags (derived from the next count so they
    // line up with count) and sticky errors, where a new error beats err_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
            afull_r  <= (AFULL_THRESH <= 0);
            aempty_r <= 1'b1;
            ovf_r    <= 1'b0;
            udf_r    <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (rd_acc_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r  <= count_nxt_s;
            full_r   <= (count_nxt_s == CNT_W'(FIFO_DEPTH));
            empty_r  <= (count_nxt_s == {CNT_W{1'b0}});
            afull_r  <= (count_nxt_s >= CNT_W'(AFULL_THRESH));
            aempty_r <= (count_nxt_s <= CNT_W'(AEMPTY_THRESH));
            ovf_r    <= (wr_en && full_r) || (ovf_r && !err_clr);
            udf_r    <= (rd_en && empty_r) || (udf_r && !err_clr);
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W),
        .FIFO_TYPE  (FIFO_TYPE)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc_s),
        .waddr (wr_ptr_r),
        .wdata (din),
        .re    (rd_acc_s),
        .raddr (rd_ptr_r),
        .rdata (ram_rdata_s)
    );

    generate
        if (FIFO_TYPE == FWFT) begin : g_fwft
            // Head word is shown whenever the FIFO holds data; zero otherwise.
            assign valid = !empty_r;
            assign dout  = empty_r ? {DATA_WIDTH{1'b0}} : ram_rdata_s;
        end else begin : g_std
            logic valid_r;

            // Read data qualifier, one cycle behind the accepted read
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_r <= 1'b0;
                end else begin
                    valid_r <= rd_acc_s;
                end
            end

            assign valid = valid_r;
            assign dout  = ram_rdata_s;
        end
    endgenerate

    assign count        = count_r;
    assign full         = full_r;
    assign empty        = empty_r;
    assign almost_full  = afull_r;
    assign almost_empty = aempty_r;
    assign overflow     = ovf_r;
    assign underflow    = udf_r;

endmodule

// File: tb/tb_sync_fifo_adv.sv
// Directed bench for sync_fifo_adv: three instances (STANDARD depth 4 with
// thresholds 3/1, STANDARD depth 5 with default thresholds, FWFT depth 4).
`timescale 1ns/1ps
module tb_sync_fifo_adv;
    import sync_fifo_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Instance A: STANDARD, depth 4, AFULL 3, AEMPTY 1
    logic a_rst, a_wr, a_rd, a_clr;
    logic [7:0] a_din, a_dout;
    logic a_valid, a_full, a_empty, a_afull, a_aempty, a_ovf, a_udf;
    logic [2:0] a_count;

    // Instance B: STANDARD, depth 5, AFULL 3 (default), AEMPTY 2
    logic b_rst, b_wr, b_rd, b_clr;
    logic [7:0] b_din, b_dout;
    logic b_valid, b_full, b_empty, b_afull, b_aempty, b_ovf, b_udf;
    logic [2:0] b_count;

    // Instance C: FWFT, depth 4, AFULL 2 (default), AEMPTY 2
    logic c_rst, c_wr, c_rd, c_clr;
    logic [7:0] c_din, c_dout;
    logic c_valid, c_full, c_empty, c_afull, c_aempty, c_ovf, c_udf;
    logic [2:0] c_count;

    sync_fifo_adv #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .FIFO_TYPE(STANDARD),
                    .AFULL_THRESH(3), .AEMPTY_THRESH(1)) u_a (
        .clk(clk), .rst(a_rst), .wr_en(a_wr), .din(a_din), .rd_en(a_rd), .err_clr(a_clr),
        .dout(a_dout), .valid(a_valid), .full(a_full), .empty(a_empty),
        .almost_full(a_afull), .almost_empty(a_aempty), .count(a_count),
        .overflow(a_ovf), .underflow(a_udf));

    sync_fifo_adv #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .FIFO_TYPE(STANDARD)) u_b (
        .clk(clk), .rst(b_rst), .wr_en(b_wr), .din(b_din), .rd_en(b_rd), .err_clr(b_clr),
        .dout(b_dout), .valid(b_valid), .full(b_full), .empty(b_empty),
        .almost_full(b_afull), .almost_empty(b_aempty), .count(b_count),
        .overflow(b_ovf), .underflow(b_udf));

    sync_fifo_adv #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .FIFO_TYPE(FWFT)) u_c (
        .clk(clk), .rst(c_rst), .wr_en(c_wr), .din(c_din), .rd_en(c_rd), .err_clr(c_clr),
        .dout(c_dout), .valid(c_valid), .full(c_full), .empty(c_empty),
        .almost_full(c_afull), .almost_empty(c_aempty), .count(c_count),
        .overflow(c_ovf), .underflow(c_udf));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] std_vals [4];

    initial begin
        std_vals = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        {a_wr, a_rd, a_clr, b_wr, b_rd, b_clr, c_wr, c_rd, c_clr} = 9'b0;
        a_din = 8'h00; b_din = 8'h00; c_din = 8'h00;
        a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
        tick();
        a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

        // Reset state
        chk("a_rst_count", a_count, 0);
        chk("a_rst_empty", a_empty, 1);
        chk("a_rst_aempty", a_aempty, 1);
        chk("a_rst_full", a_full, 0);
        chk("a_rst_afull", a_afull, 0);
        chk("a_rst_valid", a_valid, 0);
        chk("a_rst_dout", a_dout, 0);
        chk("a_rst_ovf", a_ovf, 0);
        chk("a_rst_udf", a_udf, 0);
        chk("b_rst_empty", b_empty, 1);
        chk("c_rst_valid", c_valid, 0);
        chk("c_rst_dout", c_dout, 0);

        // A: fill to full, then read back in order with latency 1
        for (int i = 0; i < 4; i++) begin
            a_wr = 1'b1; a_din = std_vals[i];
            tick();
            chk("a_fill_count", a_count, i + 1);
        end
        a_wr = 1'b0;
        chk("a_full", a_full, 1);
        chk("a_full_afull", a_afull, 1);
        chk("a_full_empty", a_empty, 0);
        chk("a_full_aempty", a_aempty, 0);
        for (int i = 0; i < 4; i++) begin
            a_rd = 1'b1;
            tick();
            chk("a_rd_dout", a_dout, std_vals[i]);
            chk("a_rd_valid", a_valid, 1);
        end
        a_rd = 1'b0;
        tick();
        chk("a_idle_valid", a_valid, 0);
        chk("a_idle_dout_hold", a_dout, 8'hD4);
        chk("a_drained_empty", a_empty, 1);
        chk("a_drained_count", a_count, 0);

        // A: simultaneous write/read while full
        a_wr = 1'b1;
        a_din = 8'h11; tick();
        a_din = 8'h22; tick();
        a_din = 8'h33; tick();
        a_din = 8'h44; tick();
        a_din = 8'h55; a_rd = 1'b1;
        tick();
        chk("a_ovf_count", a_count, 3);
        chk("a_ovf_flag", a_ovf, 1);
        chk("a_ovf_dout", a_dout, 8'h11);
        chk("a_ovf_valid", a_valid, 1);
        chk("a_ovf_full", a_full, 0);
        a_wr = 1'b0; a_rd = 1'b0; a_clr = 1'b1;
        tick();
        chk("a_clr_ovf", a_ovf, 0);
        chk("a_clr_count", a_count, 3);
        a_clr = 1'b0; a_wr = 1'b1; a_din = 8'h66;
        tick();
        chk("a_refull", a_full, 1);
        a_din = 8'h77; a_clr = 1'b1;
        tick();
        chk("a_set_beats_clr", a_ovf, 1);
        chk("a_set_count", a_count, 4);
        a_wr = 1'b0;
        tick();
        chk("a_clr2_ovf", a_ovf, 0);
        a_clr = 1'b0;

        // A: drain, then underflow behaviour
        a_rd = 1'b1;
        tick(); chk("a_drain0", a_dout, 8'h22);
        tick(); chk("a_drain1", a_dout, 8'h33);
        tick(); chk("a_drain2", a_dout, 8'h44);
        tick(); chk("a_drain3", a_dout, 8'h66);
        chk("a_drain_empty", a_empty, 1);
        tick();
        chk("a_udf_flag", a_udf, 1);
        chk("a_udf_count", a_count, 0);
        chk("a_udf_valid", a_valid, 0);
        a_wr = 1'b1; a_din = 8'h77;
        tick();
        chk("a_wr_rd_empty_count", a_count, 1);
        chk("a_udf_sticky", a_udf, 1);
        chk("a_wr_rd_empty_valid", a_valid, 0);
        chk("a_one_empty", a_empty, 0);
        chk("a_one_aempty", a_aempty, 1);
        a_rd = 1'b0;

        // A: three entries, then reset discards everything
        a_din = 8'h88; tick();
        a_din = 8'h99; tick();
        a_wr = 1'b0;
        chk("a_three_count", a_count, 3);
        chk("a_three_afull", a_afull, 1);
        chk("a_three_aempty", a_aempty, 0);
        a_rst = 1'b1; a_wr = 1'b1; a_rd = 1'b1;
        tick();
        a_rst = 1'b0; a_wr = 1'b0; a_rd = 1'b0;
        chk("a_mrst_count", a_count, 0);
        chk("a_mrst_empty", a_empty, 1);
        chk("a_mrst_aempty", a_aempty, 1);
        chk("a_mrst_afull", a_afull, 0);
        chk("a_mrst_full", a_full, 0);
        chk("a_mrst_udf", a_udf, 0);
        chk("a_mrst_ovf", a_ovf, 0);
        chk("a_mrst_valid", a_valid, 0);
        chk("a_mrst_dout", a_dout, 0);
        a_wr = 1'b1; a_din = 8'hAB;
        tick();
        a_wr = 1'b0; a_rd = 1'b1;
        tick();
        chk("a_post_rst_dout", a_dout, 8'hAB);
        chk("a_post_rst_valid", a_valid, 1);
        a_rd = 1'b0;

        // B: depth 5, fill and drain to wrap pointers once
        for (int i = 0; i < 5; i++) begin
            b_wr = 1'b1; b_din = 8'(i + 1);
            tick();
        end
        b_wr = 1'b0;
        chk("b_full", b_full, 1);
        chk("b_full_count", b_count, 5);
        chk("b_full_afull", b_afull, 1);
        for (int i = 0; i < 5; i++) begin
            b_rd = 1'b1;
            tick();
            chk("b_fill_dout", b_dout, i + 1);
        end
        b_rd = 1'b0;
        // B: 12 writes interleaved with reads, pointers wrap again
        for (int k = 0; k < 12; k++) begin
            b_wr = 1'b1; b_din = 8'(8'h10 + k);
            b_rd = (k >= 2);
            tick();
            if (k >= 2) begin
                chk("b_il_dout", b_dout, 8'h10 + k - 2);
            end
            chk("b_il_count", b_count, (k == 0) ? 1 : 2);
        end
        b_wr = 1'b0;
        b_rd = 1'b0;
        chk("b_il_aempty", b_aempty, 1);
        chk("b_il_afull", b_afull, 0);
        b_rd = 1'b1;
        tick(); chk("b_tail0", b_dout, 8'h1A);
        tick(); chk("b_tail1", b_dout, 8'h1B);
        b_rd = 1'b0;
        tick();
        chk("b_end_valid", b_valid, 0);
        chk("b_end_empty", b_empty, 1);

        // C: FWFT presentation and pop
        c_wr = 1'b1; c_din = 8'h5A;
        tick();
        c_wr = 1'b0;
        chk("c_fall_valid", c_valid, 1);
        chk("c_fall_dout", c_dout, 8'h5A);
        chk("c_fall_count", c_count, 1);
        tick();
        chk("c_hold_valid", c_valid, 1);
        chk("c_hold_dout", c_dout, 8'h5A);
        c_rd = 1'b1;
        tick();
        c_rd = 1'b0;
        chk("c_pop_valid", c_valid, 0);
        chk("c_pop_empty", c_empty, 1);
        c_wr = 1'b1;
        c_din = 8'h01; tick();
        c_din = 8'h02; tick();
        c_wr = 1'b0;
        chk("c_two_dout", c_dout, 8'h01);
        chk("c_two_afull", c_afull, 1);
        chk("c_two_aempty", c_aempty, 1);
        c_rd = 1'b1;
        tick();
        chk("c_next_dout", c_dout, 8'h02);
        chk("c_next_valid", c_valid, 1);
        tick();
        c_rd = 1'b0;
        chk("c_last_valid", c_valid, 0);
        chk("c_last_udf", c_udf, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
